// File: rtl/approx_mult_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : approx_mult_pipe_if
// Description : Operand/result streaming bundle for approx_mult_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface approx_mult_pipe_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;
    logic                 out_mode;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_result, out_mode
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_result, out_mode
    );
endinterface
`default_nettype wire

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : approx_mult_pipe
// Description : 3-stage valid/ready unsigned multiplier, exact or approximate
//               per beat; low APPROX_COLS columns are OR-reduced without carry.
//               Optional macro ERR_STAT_EN adds an approximate-error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module approx_mult_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 8
) (
    input  logic               clk,
    input  logic               rst,
    approx_mult_pipe_if.slave  bus
`ifdef ERR_STAT_EN
    ,
    input  logic               stat_clr,
    output logic [15:0]        err_cnt
`endif
);

    localparam int              c_PW      = 2 * WIDTH;
    localparam int              c_LW      = (APPROX_COLS > 0) ? APPROX_COLS : 1;
    localparam logic [c_PW-1:0] c_HI_MASK = {c_PW{1'b1}} << APPROX_COLS;

    // ------------------------------------------------------------------
    // Handshake: a stage is ready when empty or when its successor moves
    // ------------------------------------------------------------------
    logic r_v1, r_v2, r_v3;
    logic w_rdy1, w_rdy2, w_rdy3;

    assign w_rdy3       = !r_v3 || bus.out_ready;
    assign w_rdy2       = !r_v2 || w_rdy3;
    assign w_rdy1       = !r_v1 || w_rdy2;
    assign bus.in_ready = w_rdy1;

    // ------------------------------------------------------------------
    // S1: operand capture
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_a1, r_b1;
    logic             r_m1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_a1 <= '0;
            r_b1 <= '0;
            r_m1 <= 1'b0;
        end else if (w_rdy1) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_a1 <= bus.in_a;
                r_b1 <= bus.in_b;
                r_m1 <= bus.in_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2 combinational: partial products, low OR columns, high part
    // compressed row by row into a sum/carry pair
    // ------------------------------------------------------------------
    logic [c_PW-1:0] w_row;
    logic [c_PW-1:0] w_sum;
    logic [c_PW-1:0] w_carry;
    logic [c_PW-1:0] w_nsum;
    logic [c_PW-1:0] w_low;

    always_comb begin
        w_sum   = '0;
        w_carry = '0;
        w_nsum  = '0;
        w_low   = '0;
        w_row   = '0;
        for (int r = 0; r < WIDTH; r++) begin
            w_row = {{WIDTH{1'b0}}, (r_a1 & {WIDTH{r_b1[r]}})} << r;
            if (r_m1) begin
                for (int c = 0; c < WIDTH; c++) begin
                    if (r + c < APPROX_COLS) begin
                        w_low[r+c] = w_low[r+c] | (r_a1[c] & r_b1[r]);
                    end
                end
                w_row = w_row & c_HI_MASK;
            end
            // The high part never exceeds the exact product, so dropping
            // the carry out of the top column keeps the pair exact.
            w_nsum  = w_sum ^ w_carry ^ w_row;
            w_carry = ((w_sum & w_carry) | (w_sum & w_row) | (w_carry & w_row)) << 1;
            w_sum   = w_nsum;
        end
    end

    // ------------------------------------------------------------------
    // S2 registers
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_sum2, r_carry2;
    logic [c_LW-1:0] r_low2;
    logic            r_m2;
`ifdef ERR_STAT_EN
    logic [WIDTH-1:0] r_a2, r_b2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_sum2   <= '0;
            r_carry2 <= '0;
            r_low2   <= '0;
            r_m2     <= 1'b0;
`ifdef ERR_STAT_EN
            r_a2     <= '0;
            r_b2     <= '0;
`endif
        end else if (w_rdy2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sum2   <= w_sum;
                r_carry2 <= w_carry;
                r_low2   <= w_low[c_LW-1:0];
                r_m2     <= r_m1;
`ifdef ERR_STAT_EN
                r_a2     <= r_a1;
                r_b2     <= r_b1;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: carry-propagate add, merge low OR bits, output registers
    // ------------------------------------------------------------------
    logic [c_PW-1:0] w_high;
    logic [c_PW-1:0] w_result;
    logic [c_PW-1:0] r_res3;
    logic            r_m3;

    assign w_high   = r_sum2 + r_carry2;
    assign w_result = w_high | {{(c_PW - c_LW){1'b0}}, r_low2};

`ifdef ERR_STAT_EN
    logic [c_PW-1:0] w_exact;
    logic            r_err3;

    assign w_exact = c_PW'(r_a2) * c_PW'(r_b2);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3   <= 1'b0;
            r_res3 <= '0;
            r_m3   <= 1'b0;
`ifdef ERR_STAT_EN
            r_err3 <= 1'b0;
`endif
        end else if (w_rdy3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_res3 <= w_result;
                r_m3   <= r_m2;
`ifdef ERR_STAT_EN
                r_err3 <= r_m2 && (w_result != w_exact);
`endif
            end
        end
    end

    assign bus.out_valid  = r_v3;
    assign bus.out_result = r_res3;
    assign bus.out_mode   = r_m3;

`ifdef ERR_STAT_EN
    // ------------------------------------------------------------------
    // Saturating count of approximate beats that left with an inexact result
    // ------------------------------------------------------------------
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (stat_clr) begin
            r_err_cnt <= '0;
        end else if (r_v3 && bus.out_ready && r_err3 && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_mult_pipe
// Description : Self-checking bench: five approx_mult_pipe instances in lockstep
//               against a column-rule reference model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_mult_pipe;

    localparam int NDUT = 5;

    function automatic int w_of(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic int k_of(input int i);
        case (i)
            0:       return 4;
            1:       return 0;
            2:       return 5;
            3:       return 8;
            default: return 15;
        endcase
    endfunction

    // Reference: every set partial-product bit either ORs into a low column
    // (approximate mode, column < k) or adds its full column weight.
    function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b,
                                             input logic m, input int w, input int k);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = '0;
        lo = '0;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                if (a[c] && b[r]) begin
                    if (m && (r + c) < k) lo[r+c] = 1'b1;
                    else                  hi = hi + (16'd1 << (r + c));
                end
            end
        end
        return hi + lo;
    endfunction

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       in_valid  = 1'b0;
    logic       in_mode   = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_a      = '0;
    logic [7:0] in_b      = '0;
`ifdef ERR_STAT_EN
    logic        stat_clr = 1'b0;
    logic [15:0] ecnt [NDUT];
`endif

    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] ov;
    logic [NDUT-1:0] om;
    logic [15:0]     res [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar i = 0; i < NDUT; i++) begin : g_dut
            localparam int W = w_of(i);
            approx_mult_pipe_if #(.WIDTH(W)) bus ();
            assign bus.in_valid  = in_valid;
            assign bus.in_a      = in_a[W-1:0];
            assign bus.in_b      = in_b[W-1:0];
            assign bus.in_mode   = in_mode;
            assign bus.out_ready = out_ready;
            assign rdy[i]        = bus.in_ready;
            assign ov[i]         = bus.out_valid;
            assign om[i]         = bus.out_mode;
            assign res[i]        = 16'(bus.out_result);

            approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(k_of(i))) dut (
                .clk      (clk),
                .rst      (rst),
                .bus      (bus.slave)
`ifdef ERR_STAT_EN
                ,
                .stat_clr (stat_clr),
                .err_cnt  (ecnt[i])
`endif
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard: one in-order expectation list per instance
    // ------------------------------------------------------------------
    logic [16:0] sb [NDUT][64];
    int          wp [NDUT];
    int          rp [NDUT];
    logic        stall [NDUT];
    logic [15:0] held [NDUT];
    logic [16:0] sb_e;

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            wp[i] = 0; rp[i] = 0; stall[i] = 1'b0; held[i] = '0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                wp[i]    = 0;
                rp[i]    = 0;
                stall[i] = 1'b0;
            end else begin
                if (stall[i]) begin
                    chk("hold_valid", 32'(ov[i]), 32'd1);
                    chk("hold_result", 32'(res[i]), 32'(held[i]));
                end
                // Only a completely full pipeline facing backpressure refuses input
                chk("in_ready", 32'(rdy[i]), 32'(!((wp[i] - rp[i]) >= 3 && !out_ready)));
                if (ov[i]) begin
                    if (rp[i] == wp[i]) begin
                        chk("spurious_out_valid", 32'(ov[i]), 32'd0);
                        stall[i] = 1'b0;
                    end else begin
                        sb_e = sb[i][rp[i] % 64];
                        chk("result", 32'(res[i]), 32'(sb_e[15:0]));
                        chk("out_mode", 32'(om[i]), 32'(sb_e[16]));
                        if (out_ready) begin
                            rp[i]++;
                            stall[i] = 1'b0;
                        end else begin
                            stall[i] = 1'b1;
                            held[i]  = res[i];
                        end
                    end
                end else begin
                    stall[i] = 1'b0;
                end
                if (in_valid && rdy[i]) begin
                    if (wp[i] - rp[i] >= 60) chk("sb_overflow", 32'(wp[i] - rp[i]), 32'd0);
                    sb[i][wp[i] % 64] = {in_mode, ref_mult(in_a, in_b, in_mode, w_of(i), k_of(i))};
                    wp[i]++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers (called just after a rising edge)
    // ------------------------------------------------------------------
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
        @(negedge clk);
        while (!rdy[0] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_timeout", 32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_expect(input logic [7:0] a, input logic [7:0] b, input logic m,
                               input logic [15:0] exp);
        send(a, b, m);
        @(negedge clk);
        chk("latency_c1", 32'(ov[0]), 32'd0);
        @(negedge clk);
        chk("latency_c2", 32'(ov[0]), 32'd0);
        @(negedge clk);
        chk("latency_c3", 32'(ov[0]), 32'd1);
        chk("literal_result", 32'(res[0]), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        chk("model_pin_15x15_approx", 32'(ref_mult(8'd15, 8'd15, 1'b1, 4, 4)), 32'd191);
        chk("model_pin_3x3_approx", 32'(ref_mult(8'd3, 8'd3, 1'b1, 4, 4)), 32'd7);
        chk("model_pin_k0", 32'(ref_mult(8'd255, 8'd255, 1'b1, 8, 0)), 32'd65025);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("rst_out_valid", 32'(ov[i]), 32'd0);
            chk("rst_out_result", 32'(res[i]), 32'd0);
            chk("rst_out_mode", 32'(om[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1;

        // Directed operands on the 4-bit, K=4 instance
        send_expect(8'd15, 8'd15, 1'b1, 16'd191);
        send_expect(8'd15, 8'd15, 1'b0, 16'd225);
        send_expect(8'd3,  8'd3,  1'b1, 16'd7);
        send_expect(8'd3,  8'd3,  1'b0, 16'd9);
        send_expect(8'd0,  8'd15, 1'b1, 16'd0);
        send_expect(8'd0,  8'd15, 1'b0, 16'd0);

        // Backpressure: three beats fill the pipe, the fourth waits
        out_ready = 1'b0;
        send(8'd1, 8'd1, 1'b0);
        send(8'd2, 8'd3, 1'b1);
        send(8'd15, 8'd15, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(rdy[0]), 32'd0);
        chk("full_out_valid", 32'(ov[0]), 32'd1);
        chk("full_head_result", 32'(res[0]), 32'd1);
        @(posedge clk);
        #1;
        in_a = 8'd5; in_b = 8'd7; in_mode = 1'b1; in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'd5, 8'd7, 1'b1);
        repeat (8) @(posedge clk);
        #1;

        // Reset with three beats in flight
        in_valid = 1'b1; in_a = 8'd7;  in_b = 8'd9;  in_mode = 1'b1;
        @(posedge clk); #1;
        in_a = 8'd11; in_b = 8'd13; in_mode = 1'b0;
        @(posedge clk); #1;
        in_a = 8'd6;  in_b = 8'd10; in_mode = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk("midrst_out_valid", 32'(ov[i]), 32'd0);
            chk("midrst_out_result", 32'(res[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(rdy[0]), 32'd1);
        repeat (6) @(posedge clk);
        #1;

`ifdef ERR_STAT_EN
        chk("err_after_rst", 32'(ecnt[0]), 32'd0);
        send(8'd15, 8'd15, 1'b1);
        send(8'd3,  8'd3,  1'b1);
        send(8'd1,  8'd1,  1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("err_cnt_three_beats", 32'(ecnt[0]), 32'd2);
        chk("err_cnt_k0", 32'(ecnt[1]), 32'd0);
        send(8'd15, 8'd15, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("clr_beat_valid", 32'(ov[0]), 32'd1);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        chk("err_clr_wins", 32'(ecnt[0]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
`endif

        // Random traffic with random backpressure
        for (int cyc = 0; cyc < 15000; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            in_b      = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            in_mode   = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk("drained", 32'(wp[i] - rp[i]), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/approx_mult_pipe.md
Name: approx_mult_pipe

Overview:
Parametrised, pipelined successor to the 4x4 approximate multiplier. It multiplies two unsigned WIDTH-bit operands. Each transaction selects exact mode or approximate mode, where the low APPROX_COLS product columns use a carry-free OR reduction. A valid/ready handshake on both sides lets it sit in streaming datapaths (filters, MAC arrays) and apply backpressure.

Parameters:
WIDTH, 8, operand width in bits (>=2)
APPROX_COLS, 8, number of low product columns approximated in approximate mode (0..2*WIDTH-1; 0 = approximate mode equals exact)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  WIDTH  unsigned multiplicand
in_b  input  WIDTH  unsigned multiplier
in_mode  input  1  0 = exact, 1 = approximate
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out_result  output  2*WIDTH  product
out_mode  output  1  in_mode of this result, echoed

Behaviour:
- Partial product pp[r][c] = in_a[c] & in_b[r]. pp[r][c] belongs to product column r+c.
- Exact mode: out_result = in_a*in_b, full 2*WIDTH bits, no truncation.
- Approximate mode, K = APPROX_COLS:
  - Low part L: for column k < K, bit k = OR of all pp bits in column k. No carries are generated or propagated out of L.
  - High part H: exact sum of all pp bits in columns >= K, each weighted 2^column.
  - out_result = H + L, modulo 2^(2*WIDTH). It never overflows, since H + L <= exact product.
- Pipeline, 3 register stages:
  - S1: capture operands and mode.
  - S2: generate partial products and split them into low and high parts. Register L (K bits) plus the high part reduced to two carry-save vectors.
  - S3: final carry-propagate add H = sum + carry, then OR in L. Drives out_*.
- Latency: exactly 3 cycles from an accepted input (in_valid & in_ready) to out_valid, when out_ready is held high.
- Throughput: 1 beat per cycle when out_ready = 1.
- Handshake:
  - Each stage k holds a valid bit v_k and has ready_k = !v_k | ready_(k+1), where ready_4 = out_ready.
  - in_ready = ready_1. It is combinational from out_ready and the valid bits, with no combinational path from in_valid.
  - A stage loads when its upstream is valid and it is ready. Otherwise it holds its data unchanged.
- out_valid stays asserted, and out_result/out_mode stay stable, until out_ready is sampled high.
- Beats are never dropped or duplicated, and they exit in acceptance order.
- Bubbles collapse: a full pipeline holds 3 beats. After out_ready deasserts, in_ready falls only once all 3 stages are occupied.
- in_valid may assert regardless of in_ready. in_a/in_b/in_mode need only be stable in the accepting cycle.
- Reset, including mid-operation:
  - All valid bits clear immediately and asynchronously. out_valid = 0, out_result = 0, out_mode = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
  - In-flight beats are discarded.
- Mode may change on every beat. Each beat is computed in its own captured mode.

Optional Feature:
Macro ERR_STAT_EN.
- Defined:
  - The block adds ports stat_clr (input, 1, synchronous clear) and err_cnt (output, 16, count).
  - S3 also computes the exact product.
  - err_cnt increments by 1 when an approximate-mode beat leaves the block (out_valid & out_ready) and its result differs from the exact product.
  - err_cnt saturates at 16'hFFFF and resets to 0 asynchronously on rst.
  - stat_clr zeroes it next cycle. If stat_clr and a counted beat coincide, the clear wins.
- Undefined: no extra ports, no exact-product logic, and datapath behaviour is identical.

Test Plan:
1. WIDTH=4, K=4, out_ready=1; A=15, B=15, mode=1 -> out_result=191, out_valid exactly 3 cycles after acceptance. Same operands with mode=0 -> 225.
2. WIDTH=4, K=4; A=3, B=3, mode=1 -> 7; mode=0 -> 9. A=0, B=15, either mode -> 0.
3. Back-to-back beats (1,1),(2,3),(15,15),(5,7), alternating mode, with out_ready low for cycles 2-8:
   - in_ready drops after the 3rd beat is accepted.
   - Results (mode-correct) exit in order after out_ready rises.
   - No loss, no duplicates, out_result stable while stalled.
4. Random 10k beats, WIDTH=8, K in {0, 5, 8, 15}, random in_valid/out_ready -> every result matches the OR-low/exact-high reference model. K=0 -> approximate equals exact.
5. Assert rst for 1 cycle while 3 beats are in flight -> out_valid=0 and out_result=0 immediately, in_ready=1 next cycle, no stale beat ever emitted.
6. ERR_STAT_EN, WIDTH=4, K=4:
   - 3 approximate beats (15,15),(3,3),(1,1) -> err_cnt=2.
   - Then stat_clr asserted together with a counted beat -> err_cnt=0.
